j1_boot_loader: RTL
===================

Name: j1_boot_loader

Overview:
- Byte-stream boot sequencer for the j1 core: holds the CPU in reset, receives a framed program image from a byte source (UART receiver), writes it word by word into code RAM, verifies a checksum, then releases the CPU.
- Sits between the UART RX block, the code RAM write port and the j1 reset input.
- A later boot request puts the CPU back in reset and reloads it.

Parameters:
- ADDRW, 13, code RAM word-address width; matches the j1 code_addr width.
- TIMEOUT, 1000000, maximum clk cycles allowed between bytes inside a frame.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  byte available from the source
- rx_data  in  8  byte value
- rx_ready  out  1  loader accepts the byte this cycle
- boot_req  in  1  single-cycle pulse: reload the CPU
- cpu_reset  out  1  drives the j1 reset input
- code_we  out  1  code RAM write strobe
- code_waddr  out  ADDRW  code RAM word address
- code_wdata  out  16  code RAM write data
- busy  out  1  frame reception in progress
- done  out  1  last load succeeded; CPU running
- err  out  1  sticky error flag
- err_code  out  2  1 = bad length, 2 = checksum, 3 = timeout

Behaviour:
- Clock clk; reset is synchronous and active-high.
- Reset values:
  - State HUNT.
  - cpu_reset=1, code_we=0, code_waddr=0, code_wdata=0.
  - busy=0, done=0, err=0, err_code=0.
- Byte transfer occurs when rx_valid & rx_ready.
- rx_ready=1 in every state except during reset; one byte per cycle is sustainable.
- Frame format: SYNC, LEN_H, LEN_L, then LEN pairs {DAT_H, DAT_L}, then CSUM.
  - LEN is a 16-bit word count.
  - CSUM is the XOR of LEN_H, LEN_L and all data bytes.
- States and transitions:
  - HUNT: accepted byte == SYNC → LEN_H; clear err and err_code; busy=1; clear the checksum accumulator. Any other byte is dropped.
  - LEN_H: store the byte → LEN_L.
  - LEN_L: form LEN.
    - LEN==0 or LEN > 2^ADDRW → err=1, err_code=1, go to HUNT.
    - Otherwise word counter=LEN, address=0, go to DAT_H.
  - DAT_H: latch the high byte → DAT_L.
  - DAT_L: on acceptance, register code_wdata={hi,lo} and code_waddr=address, and pulse code_we for exactly one cycle in the following cycle. Then increment address and decrement the counter.
    - Counter reaches 0 → CSUM.
    - Otherwise → DAT_H.
  - CSUM: received byte == accumulator → RUN; cpu_reset deasserts the next cycle; done=1; busy=0. On mismatch: err=1, err_code=2, go to HUNT; cpu_reset stays 1 and done=0.
  - RUN: bytes are accepted and discarded. boot_req → cpu_reset=1, done=0, go to HUNT.
- The accumulator XORs every accepted byte from LEN_H through the last DAT_L.
- Timeout:
  - The cycle counter runs in LEN_H through CSUM and reloads on each accepted byte.
  - When the counter reaches TIMEOUT: err=1, err_code=3, go to HUNT.
  - Any words already written stay in RAM; the CPU stays in reset.
- Boundary cases:
  - boot_req in any state other than RUN is ignored.
  - A byte and a timeout in the same cycle: the byte wins.
  - The address never wraps, because LEN ≤ 2^ADDRW is enforced.
  - Reset mid-frame: immediate return to HUNT with reset values; a partial image is not erased.
- cpu_reset is registered and glitch-free; it is held for at least one cycle after the final code_we.

Decomposition:
- Shared package (j1_pkg), for use by a future status register:
  - State encoding enum.
  - ERR_NONE/ERR_LEN/ERR_CSUM/ERR_TIMEOUT constants.
  - Default SYNC value.
- One natural sub-module: j1_boot_timeout, a loadable down-counter with a reload input and an expire output.
- The FSM, accumulator and address/word counters stay in the top module.

Test Plan:
- Load a 2-word image: A5 00 02 12 34 AB CD, CSUM = 00^02^12^34^AB^CD = 0x42.
  - code_we pulses at addr 0 data 0x1234, then at addr 1 data 0xABCD.
  - cpu_reset falls the cycle after CSUM; done=1.
- Same frame with CSUM 0x43 → err=1, err_code=2, cpu_reset stays 1, done=0. A following correct frame loads and clears err.
- Length checks:
  - LEN=0x0000 → err_code=1 with no code_we.
  - LEN=0x2001 (ADDRW=13) → err_code=1.
  - LEN=0x2000 → 8192 writes ending at addr 0x1FFF, then RUN.
- TIMEOUT=16: send A5 00 01 12, then idle 16 cycles → err_code=3, state HUNT. Word 0 is not written; cpu_reset=1.
- Mode checks:
  - In RUN, bytes A5 00 01 are ignored and produce no code_we.
  - A boot_req pulse sets cpu_reset=1 next cycle; a new frame then loads.
- Assert reset during DAT_L of the 3rd word → all outputs return to reset values; a subsequent full frame loads correctly from address 0.

Source files
------------

// File: rtl/j1_pkg.sv
// ----------------------------------------------------------------------------
// j1_pkg
// Shared definitions for the j1 boot loader: FSM state encoding, error codes
// reported on err_code, and the default frame start byte. Kept separate so a
// status register can decode the same values without duplicating them.
// ----------------------------------------------------------------------------
package j1_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DAT_H = 3'd3,
        ST_DAT_L = 3'd4,
        ST_CSUM  = 3'd5,
        ST_RUN   = 3'd6
    } boot_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/j1_boot_timeout.sv
// ----------------------------------------------------------------------------
// j1_boot_timeout
// Inter-byte watchdog: a loadable down-counter. While load_i is high the
// counter is held at TIMEOUT; while en_i is high it counts down once per
// cycle. expire_o flags the TIMEOUT-th consecutive idle cycle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load_i      - reload to TIMEOUT (byte accepted, or watchdog not armed)
//   en_i        - count enable (inside a frame)
//   expire_o    - TIMEOUT idle cycles have elapsed (combinational)
// ----------------------------------------------------------------------------
module j1_boot_timeout #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(TIMEOUT);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CW'(TIMEOUT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A reload in the same cycle suppresses expiry, so an arriving byte wins.
    assign expire_o = en_i && !load_i && (cnt_q == CW'(1));

endmodule

// File: rtl/j1_boot_loader.sv
// ----------------------------------------------------------------------------
// j1_boot_loader
// Byte-stream boot sequencer for the j1 core. Holds the CPU in reset, receives
// a frame {SYNC, LEN_H, LEN_L, LEN x {DAT_H, DAT_L}, CSUM}, writes each word
// to code RAM from address 0, verifies the XOR checksum and releases the CPU.
// A boot_req pulse while running puts the CPU back in reset for a reload.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rx_valid/rx_data      - byte source;  rx_ready - byte accepted this cycle
//   boot_req              - reload request (honoured only while running)
//   cpu_reset             - registered j1 reset
//   code_we/waddr/wdata   - code RAM write port (one-cycle strobe per word)
//   busy, done            - frame in progress / last load good, CPU running
//   err, err_code         - sticky error flag and cause (see j1_pkg)
// ----------------------------------------------------------------------------
module j1_boot_loader
    import j1_pkg::*;
#(
    parameter int unsigned ADDRW   = 13,
    parameter int unsigned TIMEOUT = 1000000,
    parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             boot_req,
    output logic             cpu_reset,
    output logic             code_we,
    output logic [ADDRW-1:0] code_waddr,
    output logic [15:0]      code_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    // Word counter must hold 2^ADDRW, one bit wider than the address.
    localparam int unsigned CNTW    = ADDRW + 1;
    localparam logic [16:0] MAX_LEN = 17'(32'd1 << ADDRW);

    boot_state_e      state_q, state_d;
    logic [7:0]       len_h_q, len_h_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       acc_q, acc_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [CNTW-1:0]  wcnt_q, wcnt_d;
    logic             code_we_q, code_we_d;
    logic [ADDRW-1:0] code_waddr_q, code_waddr_d;
    logic [15:0]      code_wdata_q, code_wdata_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic        accept;
    logic        in_frame;
    logic        expire;
    logic [15:0] len_w;
    logic        len_bad;

    assign rx_ready = !reset;
    assign accept   = rx_valid && rx_ready;
    assign in_frame = state_q inside {ST_LEN_H, ST_LEN_L, ST_DAT_H, ST_DAT_L, ST_CSUM};
    assign len_w    = {len_h_q, rx_data};
    assign len_bad  = (len_w == 16'd0) || ({1'b0, len_w} > MAX_LEN);

    j1_boot_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept || !in_frame),
        .en_i     (in_frame),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:  if (accept && rx_data == SYNC) state_d = ST_LEN_H;
            ST_LEN_H: if (accept) state_d = ST_LEN_L;
            ST_LEN_L: if (accept) state_d = len_bad ? ST_HUNT : ST_DAT_H;
            ST_DAT_H: if (accept) state_d = ST_DAT_L;
            ST_DAT_L: if (accept) state_d = (wcnt_q == CNTW'(1)) ? ST_CSUM : ST_DAT_H;
            ST_CSUM:  if (accept) state_d = (rx_data == acc_q) ? ST_RUN : ST_HUNT;
            ST_RUN:   if (boot_req) state_d = ST_HUNT;
            default:  state_d = ST_HUNT;
        endcase
        if (expire) state_d = ST_HUNT;
    end

    always_comb begin
        len_h_d      = len_h_q;
        hi_d         = hi_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        wcnt_d       = wcnt_q;
        code_we_d    = 1'b0;
        code_waddr_d = code_waddr_q;
        code_wdata_d = code_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        case (state_q)
            ST_HUNT: if (accept && rx_data == SYNC) begin
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
                busy_d     = 1'b1;
                acc_d      = 8'h00;
            end
            ST_LEN_H: if (accept) begin
                len_h_d = rx_data;
                acc_d   = acc_q ^ rx_data;
            end
            ST_LEN_L: if (accept) begin
                acc_d = acc_q ^ rx_data;
                if (len_bad) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LEN;
                    busy_d     = 1'b0;
                end else begin
                    wcnt_d = CNTW'(len_w);
                    addr_d = '0;
                end
            end
            ST_DAT_H: if (accept) begin
                hi_d  = rx_data;
                acc_d = acc_q ^ rx_data;
            end
            ST_DAT_L: if (accept) begin
                acc_d        = acc_q ^ rx_data;
                code_we_d    = 1'b1;
                code_waddr_d = addr_q;
                code_wdata_d = {hi_q, rx_data};
                addr_d       = addr_q + ADDRW'(1);
                wcnt_d       = wcnt_q - CNTW'(1);
            end
            ST_CSUM: if (accept) begin
                busy_d = 1'b0;
                if (rx_data == acc_q) begin
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_CSUM;
                end
            end
            ST_RUN: if (boot_req) begin
                cpu_reset_d = 1'b1;
                done_d      = 1'b0;
            end
            default: ;
        endcase
        // Words already written stay in RAM; only the status reports the abort.
        if (expire) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_h_q      <= 8'h00;
            hi_q         <= 8'h00;
            acc_q        <= 8'h00;
            addr_q       <= '0;
            wcnt_q       <= '0;
            code_we_q    <= 1'b0;
            code_waddr_q <= '0;
            code_wdata_q <= 16'h0000;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            len_h_q      <= len_h_d;
            hi_q         <= hi_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            wcnt_q       <= wcnt_d;
            code_we_q    <= code_we_d;
            code_waddr_q <= code_waddr_d;
            code_wdata_q <= code_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign code_we    = code_we_q;
    assign code_waddr = code_waddr_q;
    assign code_wdata = code_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
